data_mem_lsu: RTL and testbench
===============================

// Module: data_mem_lsu
// PURPOSE
//  Load/store unit: the CPU-side initiator that drives the word-wide data RAM (addr/d/we/tick/q).
//  Turns one byte/half/word load or store request from the core into the RAM access sequence.
//  Sub-word stores are done as read-modify-write.
//  Returns sign/zero-extended load data with a one-cycle done pulse. Sits between the core datapath and the data RAM.
// PARAMETERS
//  ADDR_W   20   word-address width presented to the RAM (byte address bits [ADDR_W+1:2])
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  req        in   1       request strobe, sampled only in IDLE
//  is_store   in   1       1 = store, 0 = load (sampled with req)
//  funct3     in   3       RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  addr       in   32      byte address
//  wdata      in   32      store data (low byte/half used for SB/SH)
//  busy       out  1       high from the cycle after acceptance until RESP, inclusive
//  done       out  1       one-cycle pulse in RESP
//  err        out  1       valid with done: misaligned or illegal funct3, no RAM access made
//  rdata      out  32      load result, valid with done, held until next done
//  mem_addr   out  ADDR_W  RAM word address
//  mem_d      out  32      RAM write data
//  mem_we     out  1       RAM write enable
//  mem_tick   out  1       RAM write qualifier; high only together with mem_we
//  mem_q      in   32      RAM combinational read data for mem_addr
// BEHAVIOUR
//  Reset (async): state=IDLE. busy, done, err, rdata, mem_addr, mem_d, mem_we, mem_tick all 0.
//  FSM states: IDLE, RD, WR, RESP.
//  - IDLE, req=1: latch addr, wdata, funct3, is_store; mem_addr <= addr[ADDR_W+1:2].
//    - error -> RESP
//    - load or SB/SH -> RD
//    - SW -> WR with mem_d <= wdata
//  - RD: mem_we=0. At end of cycle capture mem_q into buffer.
//    - load -> RESP with rdata formed from buffer
//    - SB/SH -> WR
//  - WR: mem_we=1, mem_tick=1 for exactly this cycle; mem_d = merged word. -> RESP.
//  - RESP: done=1, busy=1. -> IDLE unconditionally; req here is ignored, not queued.
//  - mem_we/mem_tick are decoded from state only and are never high outside WR.
//  Latency (req accepted at edge N): error done at N+1; load and SW done at N+2; SB/SH done at N+3.
//  Lane select:
//  - byte lane = addr[1:0]; half lane = addr[1] (bits [15:0] or [31:16])
//  - B/H loads sign-extend, BU/HU zero-extend, W passes through
//  Merge: SB replaces byte addr[1:0] of buffer with wdata[7:0]; SH replaces half addr[1] with wdata[15:0]; other bytes unchanged.
//  Errors, flagged with err=1, rdata unchanged, no RAM write:
//  - H/HU with addr[0]=1
//  - W with addr[1:0]!=0
//  - funct3 in {011,110,111}
//  - store with funct3 100/101
//  Address bits above ADDR_W+1 are ignored (wrap into RAM space); no error.
//  Reset mid-operation: state returns to IDLE immediately and mem_we drops at once, so no partial write. An in-flight RMW is lost with no done pulse.
// TESTING
//  - SW addr=0x10 wdata=0xDEADBEEF; then LW 0x10 -> mem_we/mem_tick high 1 cycle at mem_addr=4; load done at N+2 with rdata=0xDEADBEEF.
//  - Word 0x11223344 at 0x20; SB addr=0x22 wdata=0xAA -> RD then WR, mem_d=0x11AA3344, done at N+3.
//  - Word 0x8000F07F at 0x30: LB 0x30 -> 0x0000007F; LB 0x31 -> 0xFFFFFFF0; LHU 0x32 -> 0x00008000; LH 0x32 -> 0xFFFF8000.
//  - LW addr=0x41, SH addr=0x43, and funct3=011 -> done at N+1 with err=1, mem_we never asserted, RAM unchanged.
//  - req held high continuously -> next acceptance only in the IDLE cycle after RESP; no back-to-back done pulses.
//  - rst_n low during WR of an SH -> mem_we/mem_tick 0 before the next edge; target word unchanged; all outputs 0.

Source files
------------

// File: rtl/data_mem_lsu.sv
// Load/store unit between the core datapath and a word-wide data RAM.
// Byte/half stores are read-modify-write; loads return sign/zero-extended data.
module data_mem_lsu #(
  parameter int unsigned ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic              i_is_store,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [31:0]       o_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_d,
  output logic              o_mem_we,
  output logic              o_mem_tick,
  input  logic [31:0]       i_mem_q
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t              r_state;
  logic                r_store;
  logic [2:0]          r_f3;
  logic [1:0]          r_lane;
  logic [15:0]         r_wdata;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_d;
  logic [31:0]         r_rdata;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_req_err;
  logic [31:0]         w_q_sh;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;
  logic [31:0]         w_merged;
  logic                w_unused;

  // Address bits above the RAM space wrap silently.
  assign w_unused = ^i_addr[31:ADDR_W+2];

  // Misalignment / illegal width check on the incoming request.
  always_comb begin
    w_req_err = 1'b0;
    case (i_funct3)
      F3_B:    w_req_err = 1'b0;
      F3_H:    w_req_err = i_addr[0];
      F3_W:    w_req_err = (i_addr[1:0] != 2'b00);
      F3_BU:   w_req_err = i_is_store;
      F3_HU:   w_req_err = i_is_store | i_addr[0];
      default: w_req_err = 1'b1;
    endcase
  end

  assign w_q_sh = i_mem_q >> {r_lane, 3'b000};
  assign w_byte = w_q_sh[7:0];
  assign w_half = r_lane[1] ? i_mem_q[31:16] : i_mem_q[15:0];

  always_comb begin
    w_load = i_mem_q;
    case (r_f3)
      F3_B:    w_load = {{24{w_byte[7]}}, w_byte};
      F3_H:    w_load = {{16{w_half[15]}}, w_half};
      F3_BU:   w_load = {24'h0, w_byte};
      F3_HU:   w_load = {16'h0, w_half};
      default: w_load = i_mem_q;
    endcase
  end

  // Sub-word store: overwrite the addressed lane of the word just read.
  always_comb begin
    w_merged = i_mem_q;
    if (r_f3 == F3_B) begin
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end else if (r_lane[1]) begin
      w_merged[31:16] = r_wdata;
    end else begin
      w_merged[15:0] = r_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_store    <= 1'b0;
      r_f3       <= 3'b000;
      r_lane     <= 2'b00;
      r_wdata    <= 16'h0;
      r_mem_addr <= '0;
      r_mem_d    <= 32'h0;
      r_rdata    <= 32'h0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_store    <= i_is_store;
            r_f3       <= i_funct3;
            r_lane     <= i_addr[1:0];
            r_wdata    <= i_wdata[15:0];
            r_mem_addr <= i_addr[ADDR_W+1:2];
            r_busy     <= 1'b1;
            if (w_req_err) begin
              r_state <= ST_RESP;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (i_is_store && (i_funct3 == F3_W)) begin
              r_mem_d <= i_wdata;
              r_state <= ST_WR;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (r_store) begin
            r_mem_d <= w_merged;
            r_state <= ST_WR;
          end else begin
            r_rdata <= w_load;
            r_state <= ST_RESP;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        ST_WR: begin
          r_state <= ST_RESP;
          r_done  <= 1'b1;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_rdata    = r_rdata;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_d    = r_mem_d;
  // Write strobes follow the WR state directly so an async reset kills them at once.
  assign o_mem_we   = (r_state == ST_WR);
  assign o_mem_tick = (r_state == ST_WR);

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu with a behavioural RAM and a result scoreboard.
module tb_data_mem_lsu;

  localparam int unsigned ADDR_W = 20;

  logic              clk;
  logic              rst_n;
  logic              req;
  logic              is_store;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_d;
  logic              mem_we;
  logic              mem_tick;
  logic [31:0]       mem_q;

  logic [31:0] ram [0:255];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        chk_rd;
    int          lat;
    int          we;
  } exp_t;

  exp_t sb_q[$];

  int          n_chk;
  int          n_fail;
  int          we_cycles;
  logic [ADDR_W-1:0] last_we_addr;
  logic [31:0] last_we_d;
  logic [31:0] last_rd;

  data_mem_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (req),
    .i_is_store (is_store),
    .i_funct3   (funct3),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_rdata    (rdata),
    .o_mem_addr (mem_addr),
    .o_mem_d    (mem_d),
    .o_mem_we   (mem_we),
    .o_mem_tick (mem_tick),
    .i_mem_q    (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_q = ram[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_we && mem_tick) ram[mem_addr[7:0]] <= mem_d;
  end

  // Write-strobe monitor: tick must track we, and record what was written.
  always @(negedge clk) begin
    if (mem_we || mem_tick) begin
      n_chk++;
      if (mem_tick !== mem_we) begin
        n_fail++;
        $display("FAIL tick_vs_we: tick=%b we=%b", mem_tick, mem_we);
      end
      if (mem_we) begin
        we_cycles++;
        last_we_addr = mem_addr;
        last_we_d    = mem_d;
      end
    end
  end

  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                       input logic chk_rd, input int exp_lat, input int exp_we, input string nm);
    exp_t e;
    exp_t g;
    int   lat;
    e.err = exp_err; e.rdata = exp_rd; e.chk_rd = chk_rd; e.lat = exp_lat; e.we = exp_we;
    sb_q.push_back(e);
    @(negedge clk);
    req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    we_cycles = 0;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_chk++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_busy: got %b want 1", nm, busy);
        end
      end
      if (done === 1'b1) lat = k;
    end
    g = sb_q.pop_front();
    n_chk++;
    if (lat != g.lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d want %0d (0 = timeout)", nm, lat, g.lat);
    end
    n_chk++;
    if (err !== g.err) begin
      n_fail++;
      $display("FAIL %s_err: got %b want %b", nm, err, g.err);
    end
    if (g.chk_rd) begin
      n_chk++;
      if (rdata !== g.rdata) begin
        n_fail++;
        $display("FAIL %s_rdata: got %h want %h", nm, rdata, g.rdata);
      end
      if (!g.err) last_rd = g.rdata;
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_pulse: done still %b", nm, done);
    end
    n_chk++;
    if (we_cycles != g.we) begin
      n_fail++;
      $display("FAIL %s_we_cycles: got %0d want %0d", nm, we_cycles, g.we);
    end
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if ({busy, done, err, rdata, mem_addr, mem_d, mem_we, mem_tick} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b rdata=%h addr=%h d=%h we=%b tick=%b",
               busy, done, err, rdata, mem_addr, mem_d, mem_we, mem_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sw_lw();
    do_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 2, 1, "sw");
    n_chk++;
    if (last_we_addr !== 20'h4 || last_we_d !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sw_write: addr=%h d=%h want 4 deadbeef", last_we_addr, last_we_d);
    end
    do_op(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 2, 0, "lw");
  endtask

  task automatic test_sb_rmw();
    ram[8] = 32'h11223344;
    do_op(1'b1, 3'b000, 32'h22, 32'hFFFFFFAA, 1'b0, 32'h0, 1'b0, 3, 1, "sb");
    n_chk++;
    if (last_we_d !== 32'h11AA3344 || ram[8] !== 32'h11AA3344) begin
      n_fail++;
      $display("FAIL sb_merge: mem_d=%h ram=%h want 11aa3344", last_we_d, ram[8]);
    end
    do_op(1'b1, 3'b001, 32'h20, 32'h1234BEEF, 1'b0, 32'h0, 1'b0, 3, 1, "sh");
    n_chk++;
    if (ram[8] !== 32'h11AABEEF) begin
      n_fail++;
      $display("FAIL sh_merge: ram=%h want 11aabeef", ram[8]);
    end
  endtask

  task automatic test_load_ext();
    ram[12] = 32'h8000F07F;
    do_op(1'b0, 3'b000, 32'h30, 32'h0, 1'b0, 32'h0000007F, 1'b1, 2, 0, "lb30");
    do_op(1'b0, 3'b000, 32'h31, 32'h0, 1'b0, 32'hFFFFFFF0, 1'b1, 2, 0, "lb31");
    do_op(1'b0, 3'b101, 32'h32, 32'h0, 1'b0, 32'h00008000, 1'b1, 2, 0, "lhu32");
    do_op(1'b0, 3'b001, 32'h32, 32'h0, 1'b0, 32'hFFFF8000, 1'b1, 2, 0, "lh32");
    do_op(1'b0, 3'b100, 32'h31, 32'h0, 1'b0, 32'h000000F0, 1'b1, 2, 0, "lbu31");
    do_op(1'b0, 3'b001, 32'h30, 32'h0, 1'b0, 32'hFFFFF07F, 1'b1, 2, 0, "lh30");
  endtask

  task automatic test_errors();
    ram[16] = 32'h12345678;
    do_op(1'b0, 3'b010, 32'h41, 32'h0, 1'b1, last_rd, 1'b1, 1, 0, "lw_mis");
    do_op(1'b1, 3'b001, 32'h43, 32'h5555, 1'b1, last_rd, 1'b1, 1, 0, "sh_mis");
    do_op(1'b0, 3'b011, 32'h40, 32'h0, 1'b1, last_rd, 1'b1, 1, 0, "f3_011");
    do_op(1'b1, 3'b100, 32'h40, 32'hAB, 1'b1, last_rd, 1'b1, 1, 0, "sbu");
    do_op(1'b0, 3'b110, 32'h40, 32'h0, 1'b1, last_rd, 1'b1, 1, 0, "f3_110");
    n_chk++;
    if (ram[16] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL err_ram: ram=%h want 12345678", ram[16]);
    end
  endtask

  task automatic test_wrap();
    do_op(1'b0, 3'b010, 32'hFFC00010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 2, 0, "wrap");
    n_chk++;
    if (mem_addr !== 20'h4) begin
      n_fail++;
      $display("FAIL wrap_addr: got %h want 4", mem_addr);
    end
  endtask

  task automatic test_back_to_back();
    int   n_done;
    logic prev;
    n_done = 0;
    prev   = 1'b0;
    @(negedge clk);
    req = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h10; wdata = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        n_chk++;
        if (prev || rdata !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL b2b_done: consecutive=%b rdata=%h", prev, rdata);
        end
      end
      prev = done;
    end
    req = 1'b0;
    n_chk++;
    if (n_done != 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 4", n_done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wr();
    ram[20] = 32'h11223344;
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; funct3 = 3'b001; addr = 32'h52; wdata = 32'h5555;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #2;
    n_chk++;
    if (mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wr_entry: we=%b want 1", mem_we);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, err, rdata, mem_addr, mem_d, mem_we, mem_tick} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: busy=%b done=%b err=%b rdata=%h addr=%h d=%h we=%b tick=%b",
               busy, done, err, rdata, mem_addr, mem_d, mem_we, mem_tick);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (ram[20] !== 32'h11223344) begin
      n_fail++;
      $display("FAIL rst_mid_ram: ram=%h want 11223344", ram[20]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 32'h0;
    do_op(1'b0, 3'b010, 32'h50, 32'h0, 1'b0, 32'h11223344, 1'b1, 2, 0, "post_rst_lw");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    n_chk = 0; n_fail = 0; we_cycles = 0;
    last_we_addr = '0; last_we_d = 32'h0; last_rd = 32'h0;
    rst_n = 1'b0; req = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    test_reset();
    test_sw_lw();
    test_sb_rmw();
    test_load_ext();
    test_errors();
    test_wrap();
    test_back_to_back();
    test_reset_mid_wr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
